// File: rtl/msk_pkg.sv
// Shared types, width helpers and clamp/saturation functions for the MSK
// cross-product demodulator.
package msk_pkg;

    typedef logic signed [63:0] wide_t;

    typedef struct packed {
        logic in_win;
        logic is_end;
    } win_tag_t;

    function automatic int prod_width(input int iq_w);
        return 2 * iq_w;
    endfunction

    function automatic int acc_width(input int iq_w, input int int_len);
        return 2 * iq_w + 1 + $clog2(int_len);
    endfunction

    // Midpoint limited so the integration window never wraps past the symbol edge.
    function automatic int clamp_mid(input int sps, input int int_len, input int adj);
        int mid;
        int lo;
        int hi;
        mid = sps / 2 + adj;
        lo  = int_len / 2;
        hi  = sps - 1 - (int_len - 1 - int_len / 2);
        if (mid < lo) mid = lo;
        if (mid > hi) mid = hi;
        return mid;
    endfunction

    function automatic wide_t sat_signed(input wide_t v, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/msk_xcorr_demod_xprod.sv
// Stage 1: registered conjugate cross-product terms p = q*i_prev, r = i*q_prev,
// with the window tag carried alongside and a one-cycle valid.
module msk_xprod
    import msk_pkg::*;
#(
    parameter int IQ_W = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic signed [IQ_W-1:0]        i_in,
    input  logic signed [IQ_W-1:0]        q_in,
    input  logic                          iq_val,
    input  win_tag_t                      tag_in,
    output logic signed [2*IQ_W-1:0]      p_out,
    output logic signed [2*IQ_W-1:0]      r_out,
    output win_tag_t                      tag_out,
    output logic                          v_out
);

    localparam int PROD_W = prod_width(IQ_W);

    logic signed [IQ_W-1:0]   i_prev_q, i_prev_d;
    logic signed [IQ_W-1:0]   q_prev_q, q_prev_d;
    logic                     have_prev_q, have_prev_d;
    logic signed [PROD_W-1:0] p_q, p_d;
    logic signed [PROD_W-1:0] r_q, r_d;
    win_tag_t                 tag_q, tag_d;
    logic                     v_q, v_d;

    always_comb begin
        i_prev_d    = i_prev_q;
        q_prev_d    = q_prev_q;
        have_prev_d = have_prev_q;
        p_d         = p_q;
        r_d         = r_q;
        tag_d       = tag_q;
        // Valid is a pulse so stage 2 never consumes the same product twice.
        v_d         = iq_val & have_prev_q;
        if (iq_val) begin
            p_d         = PROD_W'(q_in) * PROD_W'(q_prev_q == q_prev_q ? i_prev_q : i_prev_q);
            r_d         = PROD_W'(i_in) * PROD_W'(q_prev_q);
            tag_d       = tag_in;
            i_prev_d    = i_in;
            q_prev_d    = q_in;
            have_prev_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_prev_q    <= '0;
            q_prev_q    <= '0;
            have_prev_q <= 1'b0;
            p_q         <= '0;
            r_q         <= '0;
            tag_q       <= '0;
            v_q         <= 1'b0;
        end else begin
            i_prev_q    <= i_prev_d;
            q_prev_q    <= q_prev_d;
            have_prev_q <= have_prev_d;
            p_q         <= p_d;
            r_q         <= r_d;
            tag_q       <= tag_d;
            v_q         <= v_d;
        end
    end

    assign p_out   = p_q;
    assign r_out   = r_q;
    assign tag_out = tag_q;
    assign v_out   = v_q;

endmodule

// File: rtl/msk_xcorr_demod.sv
// MSK demodulator: symbol phase counter, programmable integration window,
// window accumulate/dump and saturated soft output around the cross-product stage.
module msk_xcorr_demod
    import msk_pkg::*;
#(
    parameter int IQ_W    = 16,
    parameter int SPS     = 20,
    parameter int INT_LEN = 4,
    parameter int ADJ_W   = 8,
    parameter int SOFT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [ADJ_W-1:0]  midpoint_adj,
    input  logic signed [IQ_W-1:0]   i_in,
    input  logic signed [IQ_W-1:0]   q_in,
    input  logic                     iq_val,
    output logic                     data_out,
    output logic signed [SOFT_W-1:0] soft_out,
    output logic                     data_val,
    output logic                     sat
);

    localparam int CNT_W   = $clog2(SPS);
    localparam int PROD_W  = prod_width(IQ_W);
    localparam int X_W     = PROD_W + 1;
    localparam int ACC_W   = acc_width(IQ_W, INT_LEN);
    localparam int HALF    = INT_LEN / 2;
    localparam int MID_RST = clamp_mid(SPS, INT_LEN, 0);
    localparam logic [CNT_W-1:0] WS_RST  = CNT_W'(MID_RST - HALF);
    localparam logic [CNT_W-1:0] WE_RST  = CNT_W'(MID_RST - HALF + INT_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SPS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ws_q, ws_d;
    logic [CNT_W-1:0] we_q, we_d;
    int               mid_new;
    win_tag_t         tag0;

    win_tag_t                 tag1;
    logic signed [PROD_W-1:0] p1;
    logic signed [PROD_W-1:0] r1;
    logic                     v1;

    logic signed [X_W-1:0]    x;
    logic signed [ACC_W-1:0]  x_win;
    logic signed [ACC_W-1:0]  total;
    wide_t                    sat_v;

    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     data_q, data_d;
    logic signed [SOFT_W-1:0] soft_q, soft_d;
    logic                     val_q, val_d;
    logic                     sat_q, sat_d;

    always_comb begin
        cnt_d       = cnt_q;
        ws_d        = ws_q;
        we_d        = we_q;
        tag0.in_win = (cnt_q >= ws_q) && (cnt_q <= we_q);
        tag0.is_end = (cnt_q == we_q);
        mid_new     = clamp_mid(SPS, INT_LEN, int'(midpoint_adj));
        // New midpoint is latched on the last sample so it governs the next symbol only.
        if (iq_val) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                ws_d  = CNT_W'(mid_new - HALF);
                we_d  = CNT_W'(mid_new - HALF + INT_LEN - 1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    msk_xprod #(
        .IQ_W (IQ_W)
    ) u_xprod (
        .clk     (clk),
        .reset_n (reset_n),
        .i_in    (i_in),
        .q_in    (q_in),
        .iq_val  (iq_val),
        .tag_in  (tag0),
        .p_out   (p1),
        .r_out   (r1),
        .tag_out (tag1),
        .v_out   (v1)
    );

    always_comb begin
        x     = X_W'(p1) - X_W'(r1);
        x_win = '0;
        if (tag1.in_win) x_win = ACC_W'(x);
        total = acc_q + x_win;
        sat_v = sat_signed(wide_t'(total), SOFT_W);

        acc_d  = acc_q;
        data_d = data_q;
        soft_d = soft_q;
        sat_d  = sat_q;
        val_d  = 1'b0;
        if (v1) begin
            if (tag1.is_end) begin
                data_d = (total > 0);
                soft_d = SOFT_W'(sat_v);
                sat_d  = (sat_v != wide_t'(total));
                val_d  = 1'b1;
                acc_d  = '0;
            end else if (tag1.in_win) begin
                acc_d = total;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            ws_q   <= WS_RST;
            we_q   <= WE_RST;
            acc_q  <= '0;
            data_q <= 1'b0;
            soft_q <= '0;
            val_q  <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            ws_q   <= ws_d;
            we_q   <= we_d;
            acc_q  <= acc_d;
            data_q <= data_d;
            soft_q <= soft_d;
            val_q  <= val_d;
            sat_q  <= sat_d;
        end
    end

    assign data_out = data_q;
    assign soft_out = soft_q;
    assign data_val = val_q;
    assign sat      = sat_q;

endmodule

// File: tb/tb_msk_xcorr_demod.sv
// Scoreboard bench for msk_xcorr_demod: directed MSK symbols drive two instances
// (16-bit and 8-bit soft output); monitors check every strobe against the queue.
module tb_msk_xcorr_demod;

    localparam real PI = 3.14159265358979;

    typedef struct {
        longint total;
        bit     bitv;
        longint cyc;
    } exp_t;

    logic              clk;
    logic              reset_n;
    logic signed [7:0] midpoint_adj;
    logic signed [15:0] i_in;
    logic signed [15:0] q_in;
    logic              iq_val;

    logic              d16_out, d16_val, sat16;
    logic signed [15:0] soft16;
    logic              d8_out, d8_val, sat8;
    logic signed [7:0] soft8;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;
    exp_t   q16[$];
    exp_t   q8[$];

    // reference model state
    int     cnt_m = 0;
    int     ws_m  = 8;
    int     we_m  = 11;
    longint ip_m  = 0;
    longint qp_m  = 0;
    longint acc_m = 0;
    bit     hp_m  = 0;
    bit     cur_bit = 0;
    real    theta = 0.0;

    msk_xcorr_demod #(
        .IQ_W (16), .SPS (20), .INT_LEN (4), .ADJ_W (8), .SOFT_W (16)
    ) u_dut (
        .clk (clk), .reset_n (reset_n), .midpoint_adj (midpoint_adj),
        .i_in (i_in), .q_in (q_in), .iq_val (iq_val),
        .data_out (d16_out), .soft_out (soft16), .data_val (d16_val), .sat (sat16)
    );

    msk_xcorr_demod #(
        .IQ_W (16), .SPS (20), .INT_LEN (4), .ADJ_W (8), .SOFT_W (8)
    ) u_dut8 (
        .clk (clk), .reset_n (reset_n), .midpoint_adj (midpoint_adj),
        .i_in (i_in), .q_in (q_in), .iq_val (iq_val),
        .data_out (d8_out), .soft_out (soft8), .data_val (d8_val), .sat (sat8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint bsat(input longint v, input int w);
        longint hi;
        hi = (longint'(1) << (w - 1)) - 1;
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
    endfunction

    // window bounds for SPS=20, INT_LEN=4: midpoint clamped to [2,18]
    function automatic int bclamp(input int adj);
        int m;
        m = 10 + adj;
        if (m < 2) m = 2;
        if (m > 18) m = 18;
        return m;
    endfunction

    function automatic int rnd(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    task automatic drive_sample(input int iv, input int qv, input int gap);
        longint x;
        longint tot;
        longint edge_no;
        bit     in_w;
        bit     is_e;
        int     m;
        exp_t   e;
        i_in   = 16'(iv);
        q_in   = 16'(qv);
        iq_val = 1'b1;
        @(posedge clk);
        #1;
        edge_no = cyc;
        in_w = (cnt_m >= ws_m) && (cnt_m <= we_m);
        is_e = (cnt_m == we_m);
        if (hp_m) begin
            x = longint'(qv) * ip_m - longint'(iv) * qp_m;
            if (is_e) begin
                tot = acc_m + (in_w ? x : 0);
                e.total = tot;
                e.bitv  = cur_bit;
                e.cyc   = edge_no + 1;
                q16.push_back(e);
                q8.push_back(e);
                acc_m = 0;
            end else if (in_w) begin
                acc_m = acc_m + x;
            end
        end
        if (cnt_m == 19) begin
            m = bclamp(int'(midpoint_adj));
            ws_m = m - 2;
            we_m = m + 1;
            cnt_m = 0;
        end else begin
            cnt_m++;
        end
        ip_m = iv;
        qp_m = qv;
        hp_m = 1'b1;
        iq_val = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    // dir: +1 CCW / -1 CW / 0 none, each sample advancing pi/40 (pi/2 per symbol)
    task automatic drive_symbol(input int dir, input int amp, input bit bitv,
                                input int gap, input int adj_at3, input int n);
        cur_bit = bitv;
        for (int s = 0; s < n; s++) begin
            if (s == 3 && adj_at3 != 999) midpoint_adj = 8'(adj_at3);
            theta = theta + real'(dir) * PI / 40.0;
            drive_sample(rnd(real'(amp) * $cos(theta)), rnd(real'(amp) * $sin(theta)), gap);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_data16"}, longint'(d16_out), 0);
        check({tag, "_soft16"}, longint'(soft16), 0);
        check({tag, "_val16"},  longint'(d16_val), 0);
        check({tag, "_sat16"},  longint'(sat16), 0);
        check({tag, "_data8"},  longint'(d8_out), 0);
        check({tag, "_soft8"},  longint'(soft8), 0);
        check({tag, "_val8"},   longint'(d8_val), 0);
        check({tag, "_sat8"},   longint'(sat8), 0);
    endtask

    always @(negedge clk) begin : mon16
        exp_t e;
        if (reset_n && d16_val) begin
            if (q16.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL strobe16_unexpected: got data_val=1 expected no strobe (cyc=%0d)", cyc);
            end else begin
                e = q16.pop_front();
                check("strobe16_edge", cyc, e.cyc);
                check("data16", longint'(d16_out), longint'(e.bitv));
                check("soft16", longint'(soft16), bsat(e.total, 16));
                check("sat16", longint'(sat16), longint'(bsat(e.total, 16) != e.total));
            end
        end
    end

    always @(negedge clk) begin : mon8
        exp_t e;
        if (reset_n && d8_val) begin
            if (q8.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL strobe8_unexpected: got data_val=1 expected no strobe (cyc=%0d)", cyc);
            end else begin
                e = q8.pop_front();
                check("strobe8_edge", cyc, e.cyc);
                check("data8", longint'(d8_out), longint'(e.bitv));
                check("soft8", longint'(soft8), bsat(e.total, 8));
                check("sat8", longint'(sat8), longint'(bsat(e.total, 8) != e.total));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n      = 1'b0;
        iq_val       = 1'b0;
        i_in         = '0;
        q_in         = '0;
        midpoint_adj = '0;
        #3;
        check_outputs_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // constant CCW tone
        for (int k = 0; k < 3; k++) drive_symbol(1, 8000, 1'b1, 0, 999, 20);

        // bit pattern 1,0,1,1,0 then a silent symbol (tie at zero -> 0)
        drive_symbol( 1, 8000, 1'b1, 0, 999, 20);
        drive_symbol(-1, 8000, 1'b0, 0, 999, 20);
        drive_symbol( 1, 8000, 1'b1, 0, 999, 20);
        drive_symbol( 1, 8000, 1'b1, 0, 999, 20);
        drive_symbol(-1, 8000, 1'b0, 0, 999, 20);
        drive_symbol( 0, 0,    1'b0, 0, 999, 20);

        // midpoint adjust: +5, +50 (upper clamp), -100 (lower clamp), back to 0
        drive_symbol( 1, 8000, 1'b1, 0, 5,    20);
        drive_symbol(-1, 8000, 1'b0, 0, 50,   20);
        drive_symbol( 1, 8000, 1'b1, 0, -100, 20);
        drive_symbol(-1, 8000, 1'b0, 0, 0,    20);
        drive_symbol( 1, 8000, 1'b1, 0, 999,  20);

        // iq_val every third cycle
        drive_symbol( 1, 8000, 1'b1, 2, 999, 20);
        drive_symbol(-1, 8000, 1'b0, 2, 999, 20);
        drive_symbol( 1, 8000, 1'b1, 2, 999, 20);

        // full-scale input saturates both soft widths
        drive_symbol(-1, 32767, 1'b0, 0, 999, 20);
        drive_symbol( 1, 32767, 1'b1, 0, 999, 20);

        // partial symbol, then async reset mid-window
        drive_symbol(1, 8000, 1'b1, 0, 999, 9);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        cnt_m = 0;
        ws_m  = 8;
        we_m  = 11;
        acc_m = 0;
        hp_m  = 1'b0;
        ip_m  = 0;
        qp_m  = 0;
        @(negedge clk);
        reset_n = 1'b1;
        drive_symbol( 1, 8000, 1'b1, 0, 999, 20);
        drive_symbol(-1, 8000, 1'b0, 0, 999, 20);

        repeat (5) @(posedge clk);
        #1;
        check("pending16", longint'(q16.size()), 0);
        check("pending8", longint'(q8.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/msk_xcorr_demod.md
Name: msk_xcorr_demod

Overview:
- Synthesizable, parametrised successor to the behavioural MSK phase-difference demodulator.
- Replaces atan2 plus unwrap with a conjugate cross-product discriminator: Im(z[n]·conj(z[n-1])) = q·i_prev − i·q_prev.
- Sums the discriminator over a programmable window centred on a programmable symbol midpoint, then outputs a hard bit and a saturated soft value per symbol.
- Sits between the IF-to-IQ downconverter and the bit sink / framer.

Parameters:
- IQ_W, 16, signed width of i_in/q_in.
- SPS, 20, samples per symbol (FS/F_SYM); must be ≥ 2.
- INT_LEN, 4, samples summed per symbol; 1 ≤ INT_LEN ≤ SPS.
- ADJ_W, 8, signed width of midpoint_adj.
- SOFT_W, 16, signed width of soft_out.

Ports:
- clk  in  1  sample-rate clock
- reset_n  in  1  asynchronous, active-low reset
- midpoint_adj  in  ADJ_W (signed)  offset added to SPS/2 to form the symbol midpoint
- i_in  in  IQ_W (signed)  in-phase sample
- q_in  in  IQ_W (signed)  quadrature sample
- iq_val  in  1  qualifies i_in/q_in; may have arbitrary gaps
- data_out  out  1  hard decision; 1 when the window sum is > 0
- soft_out  out  SOFT_W (signed)  window sum, saturated
- data_val  out  1  one-cycle strobe marking a new data_out/soft_out
- sat  out  1  high alongside data_val when soft_out was clipped

Behaviour:
- Reset (async, reset_n low): all state clears.
  - Outputs: data_out=0, soft_out=0, data_val=0, sat=0.
  - Internal: phase counter=0, accumulator=0, prev sample=0, have_prev=0, pipeline valids=0.
  - Mid-operation reset: the partial window is discarded; on release the counter restarts at 0.
- Phase counter cnt: advances only on iq_val; counts 0..SPS-1, then wraps to 0. No iq_val means no state change anywhere.
- Effective midpoint:
  - mid_eff = SPS/2 + midpoint_adj, clamped to [INT_LEN/2, SPS−1−(INT_LEN−1−INT_LEN/2)] so the window never wraps.
  - win_start = mid_eff − INT_LEN/2; win_end = win_start + INT_LEN − 1.
  - midpoint_adj is sampled only on the iq_val where cnt == SPS−1 (takes effect next symbol). Reset loads the unadjusted SPS/2 clamp.
- Stage 1, edge accepting sample n (iq_val=1):
  - Register p = q_in·i_prev and r = i_in·q_prev, each 2·IQ_W bits.
  - Register tags in_win = (win_start ≤ cnt ≤ win_end) and is_end = (cnt == win_end).
  - v1 <= have_prev. Then prev <= (i_in, q_in) and have_prev <= 1.
  - The first sample after reset produces no discriminator (v1=0); its window position is still counted.
- Stage 2, on v1:
  - x = p − r, width 2·IQ_W+1.
  - If in_win and not is_end: acc += x.
  - If is_end:
    - Total = acc + x if in_win, else acc.
    - data_out <= (total > 0); tie at 0 gives 0.
    - soft_out <= total saturated to SOFT_W; sat <= clipped.
    - data_val <= 1; acc <= 0.
- Accumulator width: 2·IQ_W+1+clog2(INT_LEN), no internal overflow.
- data_val: a single-cycle pulse on the edge after the stage-1 edge of the window-end sample, i.e. 2 edges of latency from accepting that sample. Otherwise 0.
- Outputs hold their values between strobes.
- Gaps in iq_val stall stage 1 only. Stage 2 consumes v1 on the next edge regardless of iq_val.
- Rotation sign: counter-clockwise rotation (positive frequency) gives positive x, so data_out=1.

Decomposition:
- msk_pkg:
  - clamp_mid() function.
  - Accumulator and product width localparam helpers.
  - sat_signed() function.
- Sub-module msk_xprod: stage-1 registered conjugate cross-product (prev-sample hold, have_prev, p/r registers, valid).
- Top module: counter, window logic, accumulate/dump, saturation.

Test Plan:
- Constant tone at +FS/(4·SPS) rotation, amplitude 8000, SPS=20, INT_LEN=4, adj=0 -> data_val every 20 iq_val; data_out=1; soft_out>0 from the first full symbol.
- Bit pattern 1,0,1,1,0 MSK-modulated (±π/2 per symbol) -> data_out reproduces 1,0,1,1,0. Also check the pulse falls 2 edges after the cnt==11 sample (window 8..11).
- midpoint_adj 0→+5 asserted at cnt=3 -> current symbol still strobes at cnt=11; next symbol strobes at cnt=16. adj=+50 -> clamped win_end=19.
- iq_val high every 3rd cycle -> identical data_out sequence to continuous iq_val; data_val count equals symbol count.
- Full-scale ±32767 input with SOFT_W=8 -> soft_out=127 or −128, sat=1 on that strobe.
- Assert reset_n low at cnt=9 for 1 cycle -> outputs 0 asynchronously. The first strobe after release comes at the 12th iq_val and excludes the pre-reset sum.
